// File: rtl/fp_accum_seq.sv
// Sequential floating-point accumulator: sums N_SAMPLES IEEE-754 singles through an
// external combinational adder. Define ACCUM_PIPE_EN to register the adder operand (adds a WAIT state).
module fp_accum_seq #(
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             flush,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_res,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [31:0]      sum_data,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt
);

`ifdef ACCUM_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2, WAIT = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_e;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              in_ready_q;
    logic              sum_valid_q;
    logic              busy_q;
    logic              take;
`ifdef ACCUM_PIPE_EN
    logic [31:0]       opnd_q, opnd_d;
`endif

    // in_ready is a register so it stays low through reset and rises on the first edge after release.
    assign take    = in_valid & in_ready_q;
    assign cnt_inc = cnt_q + ONE_CNT;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef ACCUM_PIPE_EN
        opnd_d  = opnd_q;
`endif
        if (flush && !(state_q == DONE && sum_ready)) begin
            state_d = IDLE;
            acc_d   = 32'h0000_0000;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        acc_d   = in_data;
                        cnt_d   = ONE_CNT;
                        state_d = (ONE_CNT == LAST_CNT) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (take) begin
                        cnt_d = cnt_inc;
`ifdef ACCUM_PIPE_EN
                        opnd_d  = in_data;
                        state_d = WAIT;
`else
                        acc_d   = add_res;
                        state_d = (cnt_inc == LAST_CNT) ? DONE : ACC;
`endif
                    end
                end
`ifdef ACCUM_PIPE_EN
                WAIT: begin
                    acc_d   = add_res;
                    state_d = (cnt_q == LAST_CNT) ? DONE : ACC;
                end
`endif
                DONE: begin
                    if (sum_ready) begin
                        state_d = IDLE;
                        acc_d   = 32'h0000_0000;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = 32'h0000_0000;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Status outputs are derived from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 32'h0000_0000;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ACCUM_PIPE_EN
            opnd_q      <= 32'h0000_0000;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE) || (state_d == ACC);
            sum_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
`ifdef ACCUM_PIPE_EN
            opnd_q      <= opnd_d;
`endif
        end
    end

`ifdef ACCUM_PIPE_EN
    assign add_a = (state_q == ACC || state_q == WAIT) ? acc_q  : 32'h0000_0000;
    assign add_b = (state_q == ACC || state_q == WAIT) ? opnd_q : 32'h0000_0000;
`else
    assign add_a = (state_q == ACC) ? acc_q   : 32'h0000_0000;
    assign add_b = (state_q == ACC) ? in_data : 32'h0000_0000;
`endif

    assign in_ready   = in_ready_q;
    assign sum_valid  = sum_valid_q;
    assign sum_data   = acc_q;
    assign busy       = busy_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq: directed vector table, hand-written corner sequences
// and randomized sums checked against a real-arithmetic reference model.
module tb_fp_accum_seq;

    localparam int NS    = 4;
    localparam int CNT_W = 4;
`ifdef ACCUM_PIPE_EN
    localparam int SUM_LAT   = 2;
    localparam int BURST_CYC = 6;
`else
    localparam int SUM_LAT   = 1;
    localparam int BURST_CYC = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = 32'h0;
    logic             flush = 1'b0;
    logic             sum_ready = 1'b0;
    logic             in_ready;
    logic [31:0]      add_a, add_b, add_res;
    logic             sum_valid;
    logic [31:0]      sum_data;
    logic             busy;
    logic [CNT_W-1:0] sample_cnt;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycleCount  = 0;

    typedef struct {
        logic [127:0] smp;
        int           readyDelay;
        logic [31:0]  expSum;
    } vec_t;

    vec_t vecs[4];

    fp_accum_seq #(.N_SAMPLES(NS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .add_a(add_a), .add_b(add_b),
        .add_res(add_res), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data), .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Converts between single-precision bit patterns and reals; only zero and normals are used.
    function automatic real sp2real(input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        if (b[30:23] == 8'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        d = {b[31], e, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [127:0] mk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // The external combinational adder.
    always_comb add_res = real2sp(sp2real(add_a) + sp2real(add_b));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offers one sample and waits (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [31:0] data, input int expCnt);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        for (int c = 0; c < 20 && !accepted; c++) begin
            if (in_ready === 1'b1) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept_timeout: sample %h never accepted, expected acceptance", data);
        end else begin
            checkOutput("sample_cnt", 32'(sample_cnt), 32'(expCnt));
        end
    endtask

    // Waits for the completed sum, holds sum_ready low for readyDelay cycles, then handshakes.
    task automatic waitSum(input logic [31:0] expSum, input int readyDelay, input string tag);
        int lat = 0;
        while (sum_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat + 1), 32'(SUM_LAT));
        checkOutput({tag, "_sum_valid"}, 32'(sum_valid), 32'd1);
        checkOutput({tag, "_sum_data"}, sum_data, expSum);
        for (int h = 0; h < readyDelay; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_hold_valid"}, 32'(sum_valid), 32'd1);
            checkOutput({tag, "_hold_data"}, sum_data, expSum);
            checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            checkOutput({tag, "_hold_busy"}, 32'(busy), 32'd1);
        end
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        checkOutput({tag, "_post_valid"}, 32'(sum_valid), 32'd0);
        checkOutput({tag, "_post_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_post_cnt"}, 32'(sample_cnt), 32'd0);
        checkOutput({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_post_sum_data"}, sum_data, 32'h0);
    endtask

    task automatic checkIdleZeros(input string tag);
        checkOutput({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(sample_cnt), 32'd0);
        checkOutput({tag, "_sum_data"}, sum_data, 32'h0);
        checkOutput({tag, "_add_a"}, add_a, 32'h0);
        checkOutput({tag, "_add_b"}, add_b, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startCyc;
        int tries;
        real total;

        vecs[0] = '{mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000), 0, 32'h40800000};
        vecs[1] = '{mk(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000), 2, 32'h40200000};
        vecs[2] = '{mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), 5, 32'h41000000};
        vecs[3] = '{mk(32'h40400000, 32'h40A00000, 32'hC0000000, 32'h3F800000), 1, 32'h40E00000};

        // Reset state and in_ready release timing.
        #3;
        checkIdleZeros("reset");
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        #9 rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("release_in_ready_after_edge", 32'(in_ready), 32'd1);
        checkIdleZeros("idle");

        // Directed table, back-to-back samples.
        for (int v = 0; v < 4; v++) begin
            startCyc = cycleCount;
            for (int i = 0; i < NS; i++) applyStimulus(vecs[v].smp[i*32 +: 32], i + 1);
            checkOutput($sformatf("vec%0d_burst_cycles", v), 32'(cycleCount - startCyc), 32'(BURST_CYC));
            waitSum(vecs[v].expSum, vecs[v].readyDelay, $sformatf("vec%0d", v));
        end

        // Flush after two samples with a sample offered: nothing accepted, no sum.
        applyStimulus(32'h3F800000, 1);
        applyStimulus(32'h3F800000, 2);
        tries = 0;
        while (busy === 1'b1 && in_ready !== 1'b1 && tries < 5) begin
            @(posedge clk); #1;
            tries++;
        end
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkIdleZeros("flush");
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("flush_no_sum", 32'(sum_valid), 32'd0);
        for (int i = 0; i < NS; i++) applyStimulus(32'h40000000, i + 1);
        waitSum(32'h41000000, 0, "after_flush");

        // Flush together with sum_ready in DONE behaves as a handshake.
        for (int i = 0; i < NS; i++) applyStimulus(32'h3F800000, i + 1);
        tries = 0;
        while (sum_valid !== 1'b1 && tries < 5) begin
            @(posedge clk); #1;
            tries++;
        end
        checkOutput("flushdone_valid", 32'(sum_valid), 32'd1);
        flush     = 1'b1;
        sum_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        sum_ready = 1'b0;
        checkIdleZeros("flushdone");

        // Asynchronous reset after three of four samples.
        applyStimulus(32'h3F800000, 1);
        checkOutput("acc_add_a", add_a, 32'h3F800000);
`ifndef ACCUM_PIPE_EN
        in_data = 32'h40000000;
        #1;
        checkOutput("acc_add_b", add_b, 32'h40000000);
`endif
        applyStimulus(32'h3F800000, 2);
        applyStimulus(32'h3F800000, 3);
        #2 rst_n = 1'b0;
        #1;
        checkIdleZeros("midreset");
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("midreset_no_sum", 32'(sum_valid), 32'd0);
        end
        for (int i = 0; i < NS; i++) applyStimulus(32'h3F800000, i + 1);
        waitSum(32'h40800000, 0, "after_reset");

        // Randomized sums of half-integers, checked against real arithmetic.
        for (int r = 0; r < 15; r++) begin
            total = 0.0;
            for (int i = 0; i < NS; i++) begin
                int k;
                int gap;
                k   = int'($urandom_range(64, 0)) - 32;
                gap = int'($urandom_range(2, 0));
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
                total += k * 0.5;
                applyStimulus(real2sp(k * 0.5), i + 1);
            end
            waitSum(real2sp(total), int'($urandom_range(3, 0)), $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
